mac_iterative_controller: RTL and testbench

- Sequences an unsigned multiply-accumulate over WIDTH cycles by driving one row of array-multiplier cells (a AND x partial product plus sum/carry ripple).
- One partial-product row is retired per cycle.
- Sits between the operand source and the MAC result consumer, with valid/ready handshakes on both sides.
- The running accumulator and its overflow flag are owned by this block.

---
 rtl/mac_iterative_controller.sv | 135 +++++++++++++
 tb/tb_mac_iterative_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mac_iterative_controller.sv
`default_nettype none
// ============================================================================
// Module   : mac_iterative_controller
// Purpose  : Shift-and-add unsigned MAC retiring one partial-product row per
//            cycle, with a sticky-overflow accumulator and valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module mac_iterative_controller #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a_in,
    input  logic [WIDTH-1:0]       x_in,
    input  logic                   clear_acc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     product,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   overflow,
    output logic                   busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state_q,   state_d;
    logic [WIDTH-1:0]     a_q,       a_d;
    logic [WIDTH-1:0]     x_q,       x_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [PW-1:0]        partial_q, partial_d;
    logic [PW-1:0]        product_q, product_d;
    logic [ACC_WIDTH-1:0] acc_q,     acc_d;
    logic                 ovf_q,     ovf_d;

    logic [PW-1:0]        row;
    logic [ACC_WIDTH:0]   acc_sum;

    // Row for the current multiplier bit; full 2*WIDTH so the top row never truncates.
    assign row     = x_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    assign acc_sum = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PW){1'b0}}, partial_q};

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            x_q       <= '0;
            cnt_q     <= '0;
            partial_q <= '0;
            product_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            product_q <= product_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)           state_d = S_MULT;
            S_MULT:  if (cnt_q == CNT_LAST)  state_d = S_ACC;
            S_ACC:                           state_d = S_DONE;
            S_DONE:  if (out_ready)          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        a_d       = a_q;
        x_d       = x_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        product_d = product_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                // Clear is independent of the handshake, so a same-cycle op lands on zero.
                if (clear_acc) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                if (in_valid) begin
                    a_d       = a_in;
                    x_d       = x_in;
                    cnt_d     = '0;
                    partial_d = '0;
                end
            end
            S_MULT: begin
                partial_d = partial_q + row;
                cnt_d     = cnt_q + 1'b1;
            end
            S_ACC: begin
                product_d = partial_q;
                acc_d     = acc_sum[ACC_WIDTH-1:0];
                if (acc_sum[ACC_WIDTH])
                    ovf_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        product   = product_q;
        acc_out   = acc_q;
        overflow  = ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_iterative_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_iterative_controller
// Purpose  : Directed self-checking bench for mac_iterative_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_iterative_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  x_in;
    logic        clear_acc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic [19:0] acc_out;
    logic        overflow;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int lat;
    bit irh;

    mac_iterative_controller #(.WIDTH(8), .ACC_WIDTH(20)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .x_in(x_in), .clear_acc(clear_acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .acc_out(acc_out), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Presents one operand pair at a negedge while IDLE and returns at the
    // negedge where out_valid is first seen, with the negedge count.
    task automatic run_op(input logic [7:0] a, input logic [7:0] x, input logic clr,
                          output int l, output bit ir_high);
        l = 0;
        ir_high = 1'b0;
        a_in = a; x_in = x; in_valid = 1'b1; clear_acc = clr;
        do begin
            @(negedge clk);
            in_valid = 1'b0; clear_acc = 1'b0;
            l++;
            if (in_ready) ir_high = 1'b1;
        end while (!out_valid && l < 40);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; clear_acc = 1'b0; out_ready = 1'b1;
        a_in = '0; x_in = '0;
        repeat (2) @(negedge clk);
        vectors++; if ({out_valid, busy, in_ready, overflow, product, acc_out} !== 40'd0) begin
            miscompares++; $display("FAIL reset_outputs: got ov=%b busy=%b ir=%b ovf=%b p=%0d acc=%0d want all 0",
                                    out_valid, busy, in_ready, overflow, product, acc_out); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if ({in_ready, busy, out_valid} !== 3'b100) begin
            miscompares++; $display("FAIL reset_release: got ir/busy/ov=%b%b%b want 100", in_ready, busy, out_valid); end
    endtask

    task automatic test_basic();
        run_op(8'd13, 8'd11, 1'b0, lat, irh);
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL basic_latency: got %0d want 10", lat); end
        vectors++; if (irh !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_low: got %b want 0", irh); end
        vectors++; if (product !== 16'd143) begin miscompares++; $display("FAIL basic_product: got %0d want 143", product); end
        vectors++; if (acc_out !== 20'd143) begin miscompares++; $display("FAIL basic_acc: got %0d want 143", acc_out); end
        vectors++; if ({overflow, busy} !== 2'b01) begin miscompares++; $display("FAIL basic_ovf_busy: got %b%b want 01", overflow, busy); end
        @(negedge clk);
        vectors++; if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++; $display("FAIL basic_return_idle: got ov/ir/busy=%b%b%b want 010", out_valid, in_ready, busy); end
        vectors++; if (product !== 16'd143) begin miscompares++; $display("FAIL basic_product_hold: got %0d want 143", product); end
    endtask

    task automatic test_back_to_back();
        // Clear together with the handshake: accumulation starts from zero.
        run_op(8'd255, 8'd255, 1'b1, lat, irh);
        vectors++; if (product !== 16'd65025) begin miscompares++; $display("FAIL b2b_product1: got %0d want 65025", product); end
        vectors++; if (acc_out !== 20'd65025) begin miscompares++; $display("FAIL b2b_acc1: got %0d want 65025", acc_out); end
        @(negedge clk);
        run_op(8'd255, 8'd255, 1'b0, lat, irh);
        vectors++; if (acc_out !== 20'd130050) begin miscompares++; $display("FAIL b2b_acc2: got %0d want 130050", acc_out); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 16; i++) begin
            run_op(8'd255, 8'd255, (i == 1), lat, irh);
            @(negedge clk);
        end
        vectors++; if ({overflow, acc_out} !== {1'b0, 20'd1040400}) begin
            miscompares++; $display("FAIL ovf_16: got ovf=%b acc=%0d want ovf=0 acc=1040400", overflow, acc_out); end
        run_op(8'd255, 8'd255, 1'b0, lat, irh);
        vectors++; if ({overflow, acc_out} !== {1'b1, 20'd56849}) begin
            miscompares++; $display("FAIL ovf_17: got ovf=%b acc=%0d want ovf=1 acc=56849", overflow, acc_out); end
        @(negedge clk);
        run_op(8'd255, 8'd255, 1'b0, lat, irh);
        vectors++; if ({overflow, acc_out} !== {1'b1, 20'd121874}) begin
            miscompares++; $display("FAIL ovf_sticky: got ovf=%b acc=%0d want ovf=1 acc=121874", overflow, acc_out); end
        @(negedge clk);
        clear_acc = 1'b1;
        @(negedge clk);
        clear_acc = 1'b0;
        vectors++; if ({overflow, acc_out, product} !== {1'b0, 20'd0, 16'd65025}) begin
            miscompares++; $display("FAIL ovf_clear: got ovf=%b acc=%0d p=%0d want ovf=0 acc=0 p=65025", overflow, acc_out, product); end
        run_op(8'd2, 8'd3, 1'b1, lat, irh);
        vectors++; if (acc_out !== 20'd6) begin miscompares++; $display("FAIL clear_with_handshake: got %0d want 6", acc_out); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        run_op(8'd7, 8'd9, 1'b0, lat, irh);
        vectors++; if ({product, acc_out} !== {16'd63, 20'd69}) begin
            miscompares++; $display("FAIL bp_result: got p=%0d acc=%0d want p=63 acc=69", product, acc_out); end
        for (int i = 0; i < 5; i++) begin
            a_in = 8'd100; x_in = 8'd100; in_valid = 1'b1;
            @(negedge clk);
            vectors++; if ({out_valid, in_ready, product, acc_out} !== {1'b1, 1'b0, 16'd63, 20'd69}) begin
                miscompares++; $display("FAIL bp_hold: got ov=%b ir=%b p=%0d acc=%0d want ov=1 ir=0 p=63 acc=69",
                                        out_valid, in_ready, product, acc_out); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++; $display("FAIL bp_release: got ov/ir/busy=%b%b%b want 010", out_valid, in_ready, busy); end
        @(negedge clk);
        vectors++; if ({busy, acc_out} !== {1'b0, 20'd69}) begin
            miscompares++; $display("FAIL bp_no_ghost_op: got busy=%b acc=%0d want busy=0 acc=69", busy, acc_out); end
    endtask

    task automatic test_zero_boundary();
        run_op(8'd0, 8'd200, 1'b0, lat, irh);
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL zero_latency: got %0d want 10", lat); end
        vectors++; if ({product, acc_out} !== {16'd0, 20'd69}) begin
            miscompares++; $display("FAIL zero_result: got p=%0d acc=%0d want p=0 acc=69", product, acc_out); end
        @(negedge clk);
        run_op(8'd1, 8'd128, 1'b0, lat, irh);
        vectors++; if ({product, acc_out} !== {16'd128, 20'd197}) begin
            miscompares++; $display("FAIL top_row: got p=%0d acc=%0d want p=128 acc=197", product, acc_out); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        a_in = 8'd50; x_in = 8'd60; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL arst_busy: got %b want 1", busy); end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if ({out_valid, busy, in_ready, overflow, product, acc_out} !== 40'd0) begin
            miscompares++; $display("FAIL arst_outputs: got ov=%b busy=%b ir=%b ovf=%b p=%0d acc=%0d want all 0",
                                    out_valid, busy, in_ready, overflow, product, acc_out); end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd3, 8'd5, 1'b0, lat, irh);
        vectors++; if ({product, acc_out} !== {16'd15, 20'd15}) begin
            miscompares++; $display("FAIL arst_next_op: got p=%0d acc=%0d want p=15 acc=15", product, acc_out); end
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL arst_latency: got %0d want 10", lat); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_zero_boundary();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
